// File: rtl/fetch_queue.sv
// Dual-lane fetch-to-decode instruction queue.
// Circular buffer of {instr, pc, pc+4}; two pushes and up to two pops per cycle.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              InstrF1,
    input  logic [31:0]              PCF1,
    input  logic [31:0]              PCPlus4F1,
    input  logic [31:0]              InstrF2,
    input  logic [31:0]              PCF2,
    input  logic [31:0]              PCPlus4F2,
    input  logic                     ValidF1,
    input  logic                     ValidF2,
    input  logic                     flush_i,
    input  logic [1:0]               TakeD,
    output logic                     en1,
    output logic                     en2,
    output logic [31:0]              InstrD1,
    output logic [31:0]              PCD1,
    output logic [31:0]              PCPlus4D1,
    output logic [31:0]              InstrD2,
    output logic [31:0]              PCD2,
    output logic [31:0]              PCPlus4D2,
    output logic                     ValidD1,
    output logic                     ValidD2,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] instr_m [DEPTH];
    logic [31:0] pc_m    [DEPTH];
    logic [31:0] pcp4_m  [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          w1;
    logic          w2;
    logic [1:0]    wr_n;
    logic [1:0]    take;
    logic [1:0]    pops;
    logic [AW-1:0] wr2_idx;
    logic [AW-1:0] rd2_idx;

    // Enables depend only on registered occupancy so fetch never sees
    // a combinational path from decode or redirect.
    assign en1 = (count <= CW'(DEPTH - 2));
    assign en2 = en1;

    always_comb begin
        w1      = ValidF1 && en1;
        w2      = ValidF2 && en2;
        wr_n    = {1'b0, w1} + {1'b0, w2};
        take    = (TakeD == 2'd3) ? 2'd2 : TakeD;
        pops    = (count < CW'(take)) ? count[1:0] : take;
        wr2_idx = w1 ? tail + AW'(1) : tail;
        rd2_idx = head + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (w1) begin
                instr_m[tail] <= InstrF1;
                pc_m[tail]    <= PCF1;
                pcp4_m[tail]  <= PCPlus4F1;
            end
            if (w2) begin
                instr_m[wr2_idx] <= InstrF2;
                pc_m[wr2_idx]    <= PCF2;
                pcp4_m[wr2_idx]  <= PCPlus4F2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pops);
            tail  <= tail + AW'(wr_n);
            count <= count + CW'(wr_n) - CW'(pops);
        end
    end

    always_comb begin
        ValidD1   = (count >= CW'(1));
        ValidD2   = (count >= CW'(2));
        InstrD1   = ValidD1 ? instr_m[head] : NOP;
        PCD1      = ValidD1 ? pc_m[head]    : 32'h0;
        PCPlus4D1 = ValidD1 ? pcp4_m[head]  : 32'h0;
        InstrD2   = ValidD2 ? instr_m[rd2_idx] : NOP;
        PCD2      = ValidD2 ? pc_m[rd2_idx]    : 32'h0;
        PCPlus4D2 = ValidD2 ? pcp4_m[rd2_idx]  : 32'h0;
    end

    assign count_o = count;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 8, entry count; SHALL be a power of two, at least 4.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Ports: InstrF1, PCF1, PCPlus4F1  input  32 each  lane-1 instruction, PC and PC+4 from fetch.
REQ-005 Ports: InstrF2, PCF2, PCPlus4F2  input  32 each  lane-2 instruction, PC and PC+4 from fetch (lane 2 is younger).
REQ-006 Ports: ValidF1, ValidF2  input  1 each  lane carries a real instruction this cycle.
REQ-007 Port: flush_i  input  1  redirect (mispredict or predicted taken); discard all queued and incoming entries.
REQ-008 Port: TakeD  input  2  number of head entries decode consumes this cycle (0, 1 or 2).
REQ-009 Ports: en1, en2  output  1 each  fetch lane enables; queue accepts that lane this cycle.
REQ-010 Ports: InstrD1, PCD1, PCPlus4D1, InstrD2, PCD2, PCPlus4D2  output  32 each  oldest and second-oldest queued entries.
REQ-011 Ports: ValidD1, ValidD2  output  1 each  corresponding D lane holds a queued entry.
REQ-012 Port: count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries {instr, pc, pcplus4}, with head and tail pointers that wrap modulo DEPTH.
REQ-014 en1 and en2 SHALL both equal (count_o <= DEPTH-2), computed from registered occupancy only, with no combinational path from TakeD or flush_i.
REQ-015 Write: ValidF1 && en1 writes lane 1 at the tail. ValidF2 && en2 writes lane 2 at the next slot, or at the tail if lane 1 is not written. Writes SHALL preserve program order.
REQ-016 Read outputs SHALL be combinational from storage: ValidD1 = (count_o >= 1), ValidD2 = (count_o >= 2).
REQ-017 When a ValidDn is low, InstrDn SHALL be 0x00000013 (NOP) and PCDn and PCPlus4Dn SHALL be 0.
REQ-018 Pop count SHALL equal min(TakeD, count_o); TakeD = 3 SHALL be treated as 2 and clamped the same way.
REQ-019 Head SHALL advance by the pop count.
REQ-020 Next count SHALL equal count + writes - pops; simultaneous push and pop SHALL be allowed in the same cycle, including when the queue is full or empty.
REQ-021 Occupancy SHALL never exceed DEPTH; writes are gated by REQ-014, so overflow is impossible.
REQ-022 A read SHALL see an entry one cycle after it is written; no bypass from F to D in the same cycle (latency 1).
REQ-023 flush_i SHALL have priority over all other activity: on the next edge count = 0 and head = tail = 0, incoming F lanes and TakeD that cycle are discarded.
REQ-024 flush_i held for several cycles SHALL keep the queue empty, with en1 = en2 = 1.
REQ-025 Pointer wrap SHALL be seamless: a two-entry write or read straddling index DEPTH-1 to 0 keeps entry order.

Reset
REQ-026 rst SHALL take priority over flush_i and all other inputs.
REQ-027 On rst: count_o = 0, head = tail = 0, ValidD1 = ValidD2 = 0, en1 = en2 = 1, D outputs per REQ-017.
REQ-028 Storage contents need not be cleared on reset.
REQ-029 Reset asserted mid-operation SHALL discard all entries on the same edge, identically to reset from idle.

Verification
REQ-030 Reset, then ValidF1 = ValidF2 = 1 with PCF1 = 0x0, PCF2 = 0x4, TakeD = 0 -> next cycle count_o = 2, PCD1 = 0x0, PCD2 = 0x4, ValidD1 = ValidD2 = 1.
REQ-031 Fill to 6 with DEPTH = 8 -> en1 = en2 = 1; fill to 7 -> en1 = en2 = 0. Valid F lanes while disabled -> count_o stays 7.
REQ-032 count_o = 1 and TakeD = 2 -> pop count 1, count_o = 0, ValidD1 = 0, InstrD1 = 0x00000013.
REQ-033 count_o = 4 with ValidF1 = ValidF2 = 1 and TakeD = 2 in the same cycle -> count_o = 4, head advanced by 2, new entries land at the tail in order.
REQ-034 count_o = 5 with flush_i = 1 and valid F lanes -> next cycle count_o = 0, ValidD1 = 0. The following pair written at PCF1 = 0x100 is read back at PCD1 = 0x100.
REQ-035 Stream 20 sequential PCs (0x0, 0x4, ...) with random TakeD -> D lanes emit every PC exactly once, in order, across pointer wrap.
